zynq_axi3_line_master: RTL and testbench

- Line-granular AXI3 burst master that drives the PL-side m00_axi port of top_zynq.
- Accepts one cache-line read or write request at a time from the accelerator-side memory pipe.
- Issues exactly one INCR burst per request and streams the beats.
- Sits directly upstream of the m00_axi memory: the DDR port on FPGA, the nonsynth AXI memory model in cosim.

---
 rtl/zynq_axi3_line_master_if.sv | 40 ++++
 rtl/zynq_axi3_line_master.sv | 100 ++++++++++
 tb/tb_zynq_axi3_line_master.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/zynq_axi3_line_master_if.sv
// zynq_axi3_line_master_if: AXI3 port bundle between the line master and the m00_axi memory.
interface zynq_axi3_line_master_if #(
  parameter int addr_width_p = 32,
  parameter int data_width_p = 32,
  parameter int id_width_p   = 6
);
  logic [addr_width_p-1:0]   awaddr, araddr;
  logic                      awvalid, awready, arvalid, arready;
  logic [id_width_p-1:0]     awid, arid, wid, bid, rid;
  logic [3:0]                awlen, arlen, awcache, arcache, awqos, arqos;
  logic [2:0]                awsize, arsize, awprot, arprot;
  logic [1:0]                awburst, arburst, awlock, arlock, bresp, rresp;
  logic [data_width_p-1:0]   wdata, rdata;
  logic [data_width_p/8-1:0] wstrb;
  logic                      wvalid, wready, wlast, bvalid, bready, rvalid, rready, rlast;
  modport master (
    output awaddr, awvalid, awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos,
    input  awready,
    output wdata, wstrb, wvalid, wlast, wid,
    input  wready,
    input  bvalid, bid, bresp,
    output bready,
    output araddr, arvalid, arid, arlen, arsize, arburst, arlock, arcache, arprot, arqos,
    input  arready,
    input  rdata, rvalid, rid, rlast, rresp,
    output rready
  );
  modport slave (
    input  awaddr, awvalid, awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos,
    output awready,
    input  wdata, wstrb, wvalid, wlast, wid,
    output wready,
    output bvalid, bid, bresp,
    input  bready,
    input  araddr, arvalid, arid, arlen, arsize, arburst, arlock, arcache, arprot, arqos,
    output arready,
    output rdata, rvalid, rid, rlast, rresp,
    input  rready
  );
endinterface

// File: rtl/zynq_axi3_line_master.sv
// zynq_axi3_line_master: one-line-at-a-time AXI3 INCR burst master for the m00_axi port.
module zynq_axi3_line_master #(
  parameter int addr_width_p = 32,
  parameter int data_width_p = 32,
  parameter int id_width_p   = 6,
  parameter int axi_id_p     = 0,
  parameter int burst_len_p  = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    req_v_i,
  input  logic                    req_w_i,
  input  logic [addr_width_p-1:0] req_addr_i,
  output logic                    req_ready_o,
  input  logic [data_width_p-1:0] wdata_i,
  input  logic                    wdata_v_i,
  output logic                    wdata_ready_o,
  output logic [data_width_p-1:0] rdata_o,
  output logic                    rdata_v_o,
  input  logic                    rdata_ready_i,
  output logic                    err_o,
  zynq_axi3_line_master_if.master m_axi
);
  typedef enum logic [2:0] {IDLE, AW, W, B, AR, R} state_e;
  localparam int cnt_w_lp = $clog2(burst_len_p) + 1;
  localparam logic [cnt_w_lp-1:0] last_lp = cnt_w_lp'(burst_len_p - 1);
  localparam logic [addr_width_p-1:0] off_mask_lp = addr_width_p'(burst_len_p * data_width_p / 8 - 1);
  state_e state, state_n;
  logic [addr_width_p-1:0] addr_r;
  logic [cnt_w_lp-1:0] cnt_r;
  logic err_r, w_hs, r_hs, b_hs;
  assign w_hs = m_axi.wvalid & m_axi.wready;
  assign r_hs = m_axi.rvalid & m_axi.rready;
  assign b_hs = m_axi.bvalid & m_axi.bready;
  assign err_o = err_r;
  assign rdata_o = m_axi.rdata;
  assign m_axi.wdata = wdata_i;
  assign m_axi.awaddr = addr_r;
  assign m_axi.araddr = addr_r;
  assign m_axi.awid = id_width_p'(axi_id_p);
  assign m_axi.arid = id_width_p'(axi_id_p);
  assign m_axi.wid = id_width_p'(axi_id_p);
  assign m_axi.awlen = 4'(burst_len_p - 1);
  assign m_axi.arlen = 4'(burst_len_p - 1);
  assign m_axi.awsize = 3'($clog2(data_width_p / 8));
  assign m_axi.arsize = 3'($clog2(data_width_p / 8));
  assign m_axi.awburst = 2'b01;
  assign m_axi.arburst = 2'b01;
  assign m_axi.wstrb = '1;
  assign m_axi.awlock = 2'b00;
  assign m_axi.arlock = 2'b00;
  assign m_axi.awcache = 4'b0011;
  assign m_axi.arcache = 4'b0011;
  assign m_axi.awprot = 3'b000;
  assign m_axi.arprot = 3'b000;
  assign m_axi.awqos = 4'b0000;
  assign m_axi.arqos = 4'b0000;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (req_v_i) state_n = req_w_i ? AW : AR;
      AW:   if (m_axi.awready) state_n = W;
      W:    if (w_hs && m_axi.wlast) state_n = B;
      B:    if (m_axi.bvalid) state_n = IDLE;
      AR:   if (m_axi.arready) state_n = R;
      R:    if (r_hs && m_axi.rlast) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // req_ready is held low while reset is asserted so it first rises after release
  always_comb begin
    req_ready_o = state == IDLE && !reset_i;
    m_axi.awvalid = state == AW;
    m_axi.arvalid = state == AR;
    m_axi.wvalid = state == W && wdata_v_i;
    wdata_ready_o = state == W && m_axi.wready;
    m_axi.wlast = state == W && cnt_r == last_lp;
    m_axi.bready = state == B;
    m_axi.rready = state == R && rdata_ready_i;
    rdata_v_o = state == R && m_axi.rvalid;
  end
  // rlast must coincide with the final counted beat, otherwise the line is flagged
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      addr_r <= '0;
      cnt_r <= '0;
      err_r <= 1'b0;
    end else begin
      if (req_v_i && req_ready_o) begin
        addr_r <= req_addr_i & ~off_mask_lp;
        cnt_r <= '0;
      end else if (w_hs || r_hs) cnt_r <= cnt_r + cnt_w_lp'(1);
      if ((b_hs && m_axi.bresp != 2'b00) ||
          (r_hs && (m_axi.rresp != 2'b00 || m_axi.rlast != (cnt_r == last_lp))))
        err_r <= 1'b1;
    end
endmodule

// File: tb/tb_zynq_axi3_line_master.sv
// tb_zynq_axi3_line_master: random-stall AXI slave plus line-level memory model checking the line master.
module tb_zynq_axi3_line_master;
  localparam int bl_lp = 8;
  logic clk = 0, reset_i = 1;
  always #5 clk = ~clk;
  logic req_v_i = 0, req_w_i = 0, req_ready_o, wdata_v_i = 0, wdata_ready_o;
  logic rdata_v_o, rdata_ready_i = 0, err_o;
  logic [31:0] req_addr_i = 0, wdata_i = 0, rdata_o;
  zynq_axi3_line_master_if #(.addr_width_p(32), .data_width_p(32), .id_width_p(6)) m_axi ();
  zynq_axi3_line_master #(.burst_len_p(bl_lp)) dut (
    .clk_i(clk), .reset_i(reset_i), .req_v_i(req_v_i), .req_w_i(req_w_i),
    .req_addr_i(req_addr_i), .req_ready_o(req_ready_o), .wdata_i(wdata_i),
    .wdata_v_i(wdata_v_i), .wdata_ready_o(wdata_ready_o), .rdata_o(rdata_o),
    .rdata_v_o(rdata_v_o), .rdata_ready_i(rdata_ready_i), .err_o(err_o), .m_axi(m_axi)
  );
  int checks = 0, errors = 0, cyc = 0, fin_cyc = 0, stall = 0, rlast_at = bl_lp - 1;
  int wi = bl_lp, w_beat = 0, r_beat = 0, w_cnt = 0, wlast_cnt = 0, r_cnt = 0, n = 0;
  bit bad_bresp, req_pend, b_pend, r_act, r_hs, aw_hold, ar_hold, err_exp, rw;
  logic [31:0] wsrc [bl_lp];
  logic [31:0] line, w_base, r_base, aw_prev, ar_prev, ra;
  logic [31:0] smem [int unsigned];
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] rexp [$];
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  function automatic bit go();
    return $urandom_range(99) >= stall;
  endfunction
  function automatic logic [31:0] smem_rd(int unsigned k);
    return smem.exists(k) ? smem[k] : 32'hdead0000 ^ k;
  endfunction
  function automatic logic [31:0] ref_rd(int unsigned k);
    return ref_mem.exists(k) ? ref_mem[k] : 32'hdead0000 ^ k;
  endfunction
  task automatic accept();
    req_pend = 0;
    line = req_addr_i & ~32'(bl_lp * 4 - 1);
    w_cnt = 0; wlast_cnt = 0; r_cnt = 0;
    if (req_w_i) for (int i = 0; i < bl_lp; i++) ref_mem[line / 4 + i] = wsrc[i];
    else begin
      rexp.delete();
      for (int i = 0; i <= rlast_at; i++) rexp.push_back(ref_rd(line / 4 + i));
    end
  endtask
  // drive one cycle at the falling edge, then score the handshakes the next rising edge will take
  task automatic step();
    @(negedge clk);
    cyc++;
    req_v_i = req_pend;
    m_axi.awready = go(); m_axi.wready = go(); m_axi.arready = go();
    m_axi.bvalid = b_pend; m_axi.bresp = bad_bresp ? 2'b10 : 2'b00;
    if (!r_act) m_axi.rvalid = 0;
    else if (!m_axi.rvalid || r_hs) m_axi.rvalid = go();
    m_axi.rdata = smem_rd(r_base / 4 + r_beat);
    m_axi.rlast = r_beat == rlast_at;
    m_axi.rresp = 2'b00;
    wdata_v_i = wi < bl_lp && go();
    wdata_i = wsrc[wi % bl_lp];
    rdata_ready_i = go();
    #1;
    check("err", err_o, err_exp);
    if (aw_hold) begin check("aw_hold", m_axi.awvalid, 1); check("aw_stable", m_axi.awaddr, aw_prev); end
    if (ar_hold) begin check("ar_hold", m_axi.arvalid, 1); check("ar_stable", m_axi.araddr, ar_prev); end
    aw_hold = m_axi.awvalid && !m_axi.awready; aw_prev = m_axi.awaddr;
    ar_hold = m_axi.arvalid && !m_axi.arready; ar_prev = m_axi.araddr;
    if (req_v_i && req_ready_o) accept();
    if (m_axi.awvalid && m_axi.awready) begin
      check("awaddr", m_axi.awaddr, line);
      check("awlen", m_axi.awlen, bl_lp - 1);
      check("awsize", m_axi.awsize, 2);
      check("awburst", m_axi.awburst, 1);
      check("aw_const", {m_axi.awid, m_axi.awlock, m_axi.awcache, m_axi.awprot, m_axi.awqos},
            {6'd0, 2'd0, 4'd3, 3'd0, 4'd0});
      w_base = m_axi.awaddr; w_beat = 0;
    end
    if (wdata_v_i && wdata_ready_o) wi++;
    if (m_axi.wvalid && m_axi.wready) begin
      check("wdata", m_axi.wdata, wsrc[w_beat % bl_lp]);
      check("wlast", m_axi.wlast, w_beat == bl_lp - 1);
      check("wstrb", m_axi.wstrb, 4'hf);
      smem[w_base / 4 + w_beat] = m_axi.wdata;
      w_cnt++; wlast_cnt += int'(m_axi.wlast); w_beat++;
      if (m_axi.wlast) b_pend = 1;
    end
    if (m_axi.bvalid && m_axi.bready) begin
      b_pend = 0; fin_cyc = cyc;
      if (bad_bresp) err_exp = 1;
    end
    if (m_axi.arvalid && m_axi.arready) begin
      check("araddr", m_axi.araddr, line);
      check("arlen", m_axi.arlen, bl_lp - 1);
      check("arsize", m_axi.arsize, 2);
      r_base = m_axi.araddr; r_beat = 0; r_act = 1;
    end
    if (rdata_v_o && rdata_ready_i) begin
      check("rdata", rdata_o, rexp.size() > 0 ? rexp.pop_front() : 32'hbad0bad0);
      r_cnt++;
    end
    r_hs = m_axi.rvalid && m_axi.rready;
    if (r_hs) begin
      if (m_axi.rlast) begin
        r_act = 0; fin_cyc = cyc;
        if (r_beat != bl_lp - 1) err_exp = 1;
      end
      r_beat++;
    end
  endtask
  task automatic run_txn(input bit w, input logic [31:0] a);
    int k;
    k = 0;
    req_w_i = w; req_addr_i = a; wi = w ? 0 : bl_lp; req_pend = 1;
    while (req_pend && k < 500) begin step(); k++; end
    do begin step(); k++; end while (!req_ready_o && k < 500);
    check("txn_done", req_ready_o, 1);
    check("ready_gap", cyc - fin_cyc, 1);
    if (w) begin
      check("w_beats", w_cnt, bl_lp);
      check("wlast_cnt", wlast_cnt, 1);
    end else check("r_beats", r_cnt, rlast_at + 1);
  endtask
  initial begin
    {m_axi.awready, m_axi.wready, m_axi.arready, m_axi.bvalid, m_axi.rvalid, m_axi.rlast} = '0;
    m_axi.bid = '0; m_axi.rid = '0; m_axi.bresp = '0; m_axi.rresp = '0; m_axi.rdata = '0;
    foreach (wsrc[i]) wsrc[i] = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", req_ready_o, 0);
    check("rst_valids", {m_axi.awvalid, m_axi.arvalid, m_axi.wvalid, m_axi.bready, m_axi.rready, rdata_v_o, wdata_ready_o}, 0);
    check("rst_err", err_o, 0);
    reset_i = 0;
    step();
    check("ready_after_rst", req_ready_o, 1);
    foreach (wsrc[i]) wsrc[i] = i;
    run_txn(1, 32'h1000_0004);
    run_txn(0, 32'h1000_0000);
    stall = 35;
    repeat (24) begin
      rw = 1'($urandom_range(1));
      ra = 32'h1000_0000 + 32'($urandom_range(7)) * 32 + 32'($urandom_range(31));
      if (rw) foreach (wsrc[i]) wsrc[i] = $urandom;
      run_txn(rw, ra);
    end
    rlast_at = 5;
    run_txn(0, 32'h1000_0020);
    rlast_at = bl_lp - 1;
    check("err_sticky_rlast", err_o, 1);
    stall = 0;
    foreach (wsrc[i]) wsrc[i] = $urandom;
    req_w_i = 1; req_addr_i = 32'h1000_0400; wi = 0; req_pend = 1; n = 0;
    while ((req_pend || w_cnt < 3) && n < 100) begin step(); n++; end
    #7 reset_i = 1;
    #1;
    check("midrst_valids", {m_axi.awvalid, m_axi.arvalid, m_axi.wvalid, m_axi.bready, m_axi.rready, rdata_v_o, wdata_ready_o, req_ready_o}, 0);
    check("midrst_err", err_o, 0);
    b_pend = 0; r_act = 0; r_hs = 0; aw_hold = 0; ar_hold = 0; err_exp = 0; req_pend = 0;
    m_axi.rvalid = 0; m_axi.bvalid = 0;
    @(negedge clk) reset_i = 0;
    step();
    check("midrst_ready", req_ready_o, 1);
    foreach (wsrc[i]) wsrc[i] = 32'h5a00_0000 + i;
    run_txn(1, 32'h1000_0404);
    run_txn(0, 32'h1000_0400);
    stall = 20;
    bad_bresp = 1;
    foreach (wsrc[i]) wsrc[i] = $urandom;
    run_txn(1, 32'h1000_0060);
    bad_bresp = 0;
    run_txn(0, 32'h1000_0060);
    check("err_sticky_bresp", err_o, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
